fitness_evaluator: RTL and testbench

Fabric-side evaluation engine for the genetic-circuit flow. It walks a table of test vectors in on-chip RAM, drives each input vector into the evolved circuit under test, and waits a programmable settling time. It then compares the circuit outputs against expected values under a per-bit valid mask and accumulates a saturating error count per output channel. The HPS starts a run and acknowledges its completion through PIO start/done/feedback lines. This block generalises the fixed 5-input/8-error-sum PIO arrangement to parametrised widths, channel counts and sequence counts, with autonomous memory fetch.

---
 rtl/fitness_eval_pkg.sv | 31 +++
 rtl/fitness_evaluator_error_accumulator.sv | 32 +++
 rtl/fitness_evaluator.sv | 175 +++++++++++++++++
 tb/tb_fitness_evaluator.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fitness_eval_pkg.sv
// fitness_eval_pkg
//   Shared definitions for the fitness evaluator:
//   - state_t        : evaluation FSM states
//   - EXP_LSB/MASK_LSB/WORDS_PER_VEC : layout of one test vector in RAM
//   - settle_cnt_w() : width of the settle down-counter
package fitness_eval_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_IN,
        ST_RD_EXP,
        ST_LATCH,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE,
        ST_ACK
    } state_t;

    // Word 2k holds the input vector; word 2k+1 holds expected value and mask.
    localparam int EXP_LSB       = 0;
    localparam int MASK_LSB      = 16;
    localparam int WORDS_PER_VEC = 2;

    // Counter must hold SETTLE_CYCLES-1; never narrower than one bit.
    function automatic int settle_cnt_w(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fitness_evaluator_error_accumulator.sv
// error_accumulator
//   One output channel's saturating error counter.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     clear       : zero the counter (wins over enable)
//     enable      : compare cycle strobe
//     increment   : this channel mismatched under its mask
//     sum         : current count, sticks at all-ones
module error_accumulator
    import fitness_eval_pkg::*;
#(
    parameter int ERR_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             increment,
    output logic [ERR_W-1:0] sum
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (enable && increment && (sum != {ERR_W{1'b1}})) begin
            sum <= sum + ERR_W'(1);
        end
    end

endmodule

// File: rtl/fitness_evaluator.sv
// fitness_evaluator
//   Walks N test vectors in RAM, drives each into the circuit under test,
//   waits SETTLE_CYCLES, then accumulates masked per-channel mismatches.
//   Ports:
//     clk_clk, reset_reset_n       : clock, asynchronous active-low reset
//     start_processing             : HPS level start request
//     done_feedback                : HPS acknowledge of done
//     sequences_to_process         : vector count N, sampled at start
//     ready_to_process             : high only while idle
//     done_processing              : run finished, error_sum stable
//     mem_*                        : read-only RAM port (1-cycle read latency)
//     circ_in / circ_out           : circuit under test stimulus / response
//     error_sum                    : channel c at [c*ERR_W +: ERR_W]
//   Handshake: start is a level; a run is accepted only in IDLE. After done,
//   the HPS raises done_feedback; the FSM then waits in ACK until both start
//   and done_feedback are low so a start left high cannot retrigger a run.
module fitness_evaluator
    import fitness_eval_pkg::*;
#(
    parameter int IN_W          = 5,
    parameter int OUT_CH        = 8,
    parameter int ERR_W         = 32,
    parameter int ADDR_W        = 14,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    start_processing,
    input  logic                    done_feedback,
    input  logic [ADDR_W-1:0]       sequences_to_process,
    output logic                    ready_to_process,
    output logic                    done_processing,
    output logic [ADDR_W-1:0]       mem_address,
    output logic                    mem_chipselect,
    output logic                    mem_clken,
    output logic                    mem_write,
    output logic [3:0]              mem_byteenable,
    input  logic [31:0]             mem_readdata,
    output logic [IN_W-1:0]         circ_in,
    input  logic [OUT_CH-1:0]       circ_out,
    output logic [OUT_CH*ERR_W-1:0] error_sum
);

    localparam int SW = settle_cnt_w(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    // Vector index bits that fit in the word address.
    localparam int VEC_IDX_W = ADDR_W - $clog2(WORDS_PER_VEC);
    localparam logic [ADDR_W-1:0] N_MAX = {1'b1, {(ADDR_W-1){1'b0}}};

    state_t              state;
    logic [ADDR_W-1:0]   n_q;
    logic [ADDR_W-1:0]   k_q;
    logic [ADDR_W-1:0]   k_next;
    logic [ADDR_W-1:0]   n_clamped;
    logic [OUT_CH-1:0]   exp_q;
    logic [OUT_CH-1:0]   mask_q;
    logic [SW-1:0]       settle_cnt;
    logic [OUT_CH-1:0]   mismatch;
    logic                acc_clear;
    logic                acc_en;
    logic                unused_rd;

    assign k_next    = k_q + ADDR_W'(1);
    assign n_clamped = (sequences_to_process > N_MAX) ? N_MAX : sequences_to_process;

    assign mem_clken      = mem_chipselect;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;

    // Only parts of each RAM word carry data.
    assign unused_rd = ^mem_readdata;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state            <= ST_IDLE;
            ready_to_process <= 1'b1;
            done_processing  <= 1'b0;
            mem_address      <= '0;
            mem_chipselect   <= 1'b0;
            circ_in          <= '0;
            n_q              <= '0;
            k_q              <= '0;
            exp_q            <= '0;
            mask_q           <= '0;
            settle_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_processing) begin
                        n_q              <= n_clamped;
                        k_q              <= '0;
                        ready_to_process <= 1'b0;
                        if (n_clamped == '0) begin
                            state           <= ST_DONE;
                            done_processing <= 1'b1;
                        end else begin
                            state          <= ST_RD_IN;
                            mem_address    <= '0;
                            mem_chipselect <= 1'b1;
                        end
                    end
                end
                ST_RD_IN: begin
                    state          <= ST_RD_EXP;
                    mem_address    <= {k_q[VEC_IDX_W-1:0], 1'b1};
                    mem_chipselect <= 1'b1;
                end
                ST_RD_EXP: begin
                    // Word 2k arrives now (address was presented in RD_IN).
                    state          <= ST_LATCH;
                    mem_chipselect <= 1'b0;
                    circ_in        <= mem_readdata[IN_W-1:0];
                end
                ST_LATCH: begin
                    state      <= ST_SETTLE;
                    exp_q      <= mem_readdata[EXP_LSB +: OUT_CH];
                    mask_q     <= mem_readdata[MASK_LSB +: OUT_CH];
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= ST_COMPARE;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
                ST_COMPARE: begin
                    k_q <= k_next;
                    if (k_next == n_q) begin
                        state           <= ST_DONE;
                        done_processing <= 1'b1;
                    end else begin
                        state          <= ST_RD_IN;
                        mem_address    <= {k_next[VEC_IDX_W-1:0], 1'b0};
                        mem_chipselect <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (done_feedback) begin
                        state           <= ST_ACK;
                        done_processing <= 1'b0;
                    end
                end
                ST_ACK: begin
                    if (!start_processing && !done_feedback) begin
                        state            <= ST_IDLE;
                        ready_to_process <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Accumulators update on the edge that ends COMPARE.
    assign acc_clear = (state == ST_IDLE) && start_processing;
    assign acc_en    = (state == ST_COMPARE);
    assign mismatch  = (circ_out ^ exp_q) & mask_q;

    for (genvar c = 0; c < OUT_CH; c++) begin : g_acc
        error_accumulator #(
            .ERR_W(ERR_W)
        ) u_acc (
            .clk      (clk_clk),
            .rst_n    (reset_reset_n),
            .clear    (acc_clear),
            .enable   (acc_en),
            .increment(mismatch[c]),
            .sum      (error_sum[c*ERR_W +: ERR_W])
        );
    end

endmodule

// File: tb/tb_fitness_evaluator.sv
// tb_fitness_evaluator
//   Two evaluator instances: dut_a with default widths, dut_b with ERR_W=4
//   for saturation. A shared RAM array and a circuit response table back both.
module tb_fitness_evaluator;
    import fitness_eval_pkg::*;

    localparam int IN_W   = 5;
    localparam int OUT_CH = 8;
    localparam int ADDR_W = 14;
    localparam int SETTLE = 4;
    localparam int P      = 4 + SETTLE;
    localparam int ERR_A  = 32;
    localparam int ERR_B  = 4;
    localparam int MAXN   = 24;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic                    start_a = 1'b0, start_b = 1'b0, fb = 1'b0;
    logic [ADDR_W-1:0]       seq = '0;
    logic                    ready_a, done_a, cs_a, clken_a, wr_a;
    logic                    ready_b, done_b, cs_b, clken_b, wr_b;
    logic [ADDR_W-1:0]       addr_a, addr_b;
    logic [3:0]              be_a, be_b;
    logic [31:0]             rdata_a, rdata_b;
    logic [IN_W-1:0]         cin_a, cin_b;
    logic [OUT_CH-1:0]       cout_a, cout_b;
    logic [OUT_CH*ERR_A-1:0] sum_a;
    logic [OUT_CH*ERR_B-1:0] sum_b;

    logic [31:0]       ram  [0:63];
    logic [OUT_CH-1:0] resp [0:31];

    always @(posedge clk) begin
        rdata_a <= ram[addr_a[5:0]];
        rdata_b <= ram[addr_b[5:0]];
    end
    assign cout_a = resp[cin_a];
    assign cout_b = resp[cin_b];

    fitness_evaluator dut_a (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .start_processing(start_a), .done_feedback(fb),
        .sequences_to_process(seq),
        .ready_to_process(ready_a), .done_processing(done_a),
        .mem_address(addr_a), .mem_chipselect(cs_a), .mem_clken(clken_a),
        .mem_write(wr_a), .mem_byteenable(be_a), .mem_readdata(rdata_a),
        .circ_in(cin_a), .circ_out(cout_a), .error_sum(sum_a)
    );

    fitness_evaluator #(.ERR_W(ERR_B)) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .start_processing(start_b), .done_feedback(fb),
        .sequences_to_process(seq),
        .ready_to_process(ready_b), .done_processing(done_b),
        .mem_address(addr_b), .mem_chipselect(cs_b), .mem_clken(clken_b),
        .mem_write(wr_b), .mem_byteenable(be_b), .mem_readdata(rdata_b),
        .circ_in(cin_b), .circ_out(cout_b), .error_sum(sum_b)
    );

    // ---------------- selected-DUT view ----------------
    int                sel = 0;
    logic              m_ready, m_done, m_cs, m_clken;
    logic [ADDR_W-1:0] m_addr;
    logic [IN_W-1:0]   m_cin;
    logic [31:0]       m_sum [0:OUT_CH-1];

    always_comb begin
        m_ready = (sel != 0) ? ready_b : ready_a;
        m_done  = (sel != 0) ? done_b  : done_a;
        m_cs    = (sel != 0) ? cs_b    : cs_a;
        m_clken = (sel != 0) ? clken_b : clken_a;
        m_addr  = (sel != 0) ? addr_b  : addr_a;
        m_cin   = (sel != 0) ? cin_b   : cin_a;
        for (int c = 0; c < OUT_CH; c++) begin
            m_sum[c] = (sel != 0) ? 32'(sum_b[c*ERR_B +: ERR_B]) : sum_a[c*ERR_A +: ERR_A];
        end
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pref[j][c]: expected channel-c sum after the first j vectors.
    logic [31:0] pref [0:MAXN][0:OUT_CH-1];
    int          m_n    = 0;
    int unsigned t0     = 0;
    bit          mon_on = 1'b0;

    function automatic logic [31:0] in_of(input int j);
        return 32'(ram[2*j][IN_W-1:0]);
    endfunction

    task automatic build_model(input int n, input logic [31:0] sat);
        logic [31:0]       acc [0:OUT_CH-1];
        logic [OUT_CH-1:0] out_v, exp_v, msk_v;
        for (int c = 0; c < OUT_CH; c++) begin
            acc[c]     = 0;
            pref[0][c] = 0;
        end
        for (int j = 0; j < n; j++) begin
            out_v = resp[ram[2*j][IN_W-1:0]];
            exp_v = ram[2*j+1][OUT_CH-1:0];
            msk_v = ram[2*j+1][16 +: OUT_CH];
            for (int c = 0; c < OUT_CH; c++) begin
                if ((out_v[c] != exp_v[c]) && msk_v[c] && (acc[c] < sat)) acc[c] = acc[c] + 1;
                pref[j+1][c] = acc[c];
            end
        end
    endtask

    // rel = cycles since the cycle in which IDLE saw start.
    task automatic check_cycle(input int rel);
        int          t_done, j, ph, nv;
        bit          exp_cs, have_in;
        logic [31:0] exp_in;
        t_done  = 1 + m_n * P;
        j       = 0;
        ph      = 0;
        nv      = 0;
        exp_cs  = 1'b0;
        have_in = 1'b0;
        exp_in  = '0;
        if (rel >= 1) begin
            chk("ready", 32'(m_ready), 0);
            chk("done", 32'(m_done), (rel >= t_done) ? 1 : 0);
            if (rel < t_done) begin
                j      = (rel - 1) / P;
                ph     = (rel - 1) % P;
                nv     = j;
                exp_cs = (ph < 2);
                if (ph >= 2) begin
                    exp_in  = in_of(j);
                    have_in = 1'b1;
                end else if (j > 0) begin
                    exp_in  = in_of(j - 1);
                    have_in = 1'b1;
                end
            end else begin
                nv = m_n;
                if (m_n > 0) begin
                    exp_in  = in_of(m_n - 1);
                    have_in = 1'b1;
                end
            end
            chk("chipselect", 32'(m_cs), 32'(exp_cs));
            chk("clken", 32'(m_clken), 32'(exp_cs));
            if (exp_cs) chk("address", 32'(m_addr), 32'(2 * j + ph));
            if (have_in) chk("circ_in", 32'(m_cin), exp_in);
            for (int c = 0; c < OUT_CH; c++) begin
                chk($sformatf("error_sum[%0d]", c), m_sum[c], pref[nv][c]);
            end
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_on) check_cycle(int'(cyc - t0));
    end

    // ---------------- driver tasks ----------------
    task automatic set_start(input logic v);
        if (sel != 0) start_b = v;
        else          start_a = v;
    endtask

    // Starts a run of n vectors; returns with the DUT in DONE.
    task automatic run(input int s, input int n, input bit hold, output int done_rel);
        sel = s;
        build_model(n, (s != 0) ? 32'd15 : 32'hFFFF_FFFF);
        done_rel = -1;
        @(negedge clk);
        seq    = ADDR_W'(n);
        set_start(1'b1);
        t0     = cyc;
        m_n    = n;
        mon_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0 && !hold) set_start(1'b0);
            if (m_done) begin
                done_rel = int'(cyc - t0);
                break;
            end
        end
        if (done_rel < 0) chk("done_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic ack();
        bit ok;
        @(negedge clk);
        mon_on = 1'b0;
        fb     = 1'b1;
        set_start(1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!m_done) begin
                ok = 1'b1;
                break;
            end
        end
        fb = 1'b0;
        if (!ok) chk("ack_done_fall_timeout", 0, 1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ack_ready_timeout", 0, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int dr;
        bit found;
        logic [7:0] v_in  [0:5];
        logic [7:0] v_out [0:5];
        logic [7:0] v_exp [0:5];
        logic [7:0] v_msk [0:5];
        logic [7:0] rv;

        for (int i = 0; i < 64; i++) ram[i] = '0;
        for (int i = 0; i < 32; i++) resp[i] = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready_a", 32'(ready_a), 1);
        chk("rst_done_a", 32'(done_a), 0);
        chk("rst_cs_a", 32'(cs_a), 0);
        chk("rst_be_a", 32'(be_a), 32'hF);
        chk("rst_write_a", 32'(wr_a), 0);
        chk("rst_circ_in_a", 32'(cin_a), 0);
        chk("rst_ready_b", 32'(ready_b), 1);
        chk("rst_sum0_a", sum_a[31:0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single vector: 0x15 in, expect 0xA5 under mask 0xFF, circuit gives 0xA4
        ram[0] = 32'h0000_0015;
        ram[1] = 32'h00FF_00A5;
        resp[5'h15] = 8'hA4;
        run(0, 1, 1'b0, dr);
        chk("single_done_cycle", 32'(dr), 9);
        chk("single_circ_in", 32'(cin_a), 32'h15);
        chk("single_sum0", sum_a[0 +: 32], 1);
        for (int c = 1; c < OUT_CH; c++) chk($sformatf("single_sum%0d", c), sum_a[c*32 +: 32], 0);
        ack();

        // N=0: done one cycle after accept, no reads, sums cleared
        run(0, 0, 1'b0, dr);
        chk("n0_done_cycle", 32'(dr), 1);
        chk("n0_sum0", sum_a[0 +: 32], 0);
        ack();

        // Mask 0: mismatch ignored
        ram[1] = 32'h0000_00A5;
        run(0, 1, 1'b0, dr);
        chk("mask0_sum0", sum_a[0 +: 32], 0);
        ack();

        // Six directed vectors with junk in the unused word bits
        v_in  = '{8'h01, 8'h02, 8'h1F, 8'h0A, 8'h02, 8'h11};
        v_out = '{8'h3C, 8'hF0, 8'h81, 8'h55, 8'hF0, 8'h00};
        v_exp = '{8'h3C, 8'h0F, 8'h80, 8'hAA, 8'h0F, 8'hFF};
        v_msk = '{8'hFF, 8'hFF, 8'h01, 8'hF0, 8'h0F, 8'h80};
        for (int j = 0; j < 6; j++) begin
            resp[v_in[j][4:0]] = v_out[j];
            ram[2*j]   = 32'hDEAD_BEE0 | 32'(v_in[j]);
            ram[2*j+1] = 32'h5A00_5A00 | (32'(v_msk[j]) << 16) | 32'(v_exp[j]);
        end
        run(0, 6, 1'b0, dr);
        chk("multi_done_cycle", 32'(dr), 49);
        chk("multi_sum0", sum_a[0*32 +: 32], 3);
        chk("multi_sum3", sum_a[3*32 +: 32], 2);
        chk("multi_sum7", sum_a[7*32 +: 32], 3);
        ack();

        // Saturation on the 4-bit instance: 20 hits on channel 3
        for (int j = 0; j < 20; j++) begin
            rv = 8'(j * 13);
            resp[j] = rv;
            ram[2*j]   = 32'(j);
            ram[2*j+1] = 32'h0008_0000 | 32'(rv ^ 8'h08);
        end
        run(1, 20, 1'b0, dr);
        chk("sat_done_cycle", 32'(dr), 161);
        chk("sat_sum3", 32'(sum_b[3*4 +: 4]), 15);
        chk("sat_sum2", 32'(sum_b[2*4 +: 4]), 0);
        ack();

        // Handshake: start held high through DONE
        ram[0] = 32'h0000_0015;
        ram[1] = 32'h00FF_00A5;
        resp[5'h15] = 8'hA4;
        run(0, 1, 1'b1, dr);
        @(negedge clk);
        mon_on = 1'b0;
        fb = 1'b1;
        @(negedge clk);
        fb = 1'b0;
        chk("hs_done_fell", 32'(done_a), 0);
        chk("hs_state_ack", 32'(dut_a.state), 32'(ST_ACK));
        repeat (3) begin
            @(negedge clk);
            chk("hs_hold_ack", 32'(dut_a.state), 32'(ST_ACK));
            chk("hs_no_rerun_ready", 32'(ready_a), 0);
            chk("hs_no_rerun_cs", 32'(cs_a), 0);
        end
        chk("hs_sum_held", sum_a[0 +: 32], 1);
        start_a = 1'b0;
        fb = 1'b1;
        @(negedge clk);
        chk("hs_fb_high_ack", 32'(dut_a.state), 32'(ST_ACK));
        fb = 1'b0;
        @(negedge clk);
        chk("hs_idle", 32'(dut_a.state), 32'(ST_IDLE));
        chk("hs_ready", 32'(ready_a), 1);

        // Reset in the middle of SETTLE
        sel = 0;
        @(negedge clk);
        seq = 1;
        start_a = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dut_a.state == ST_SETTLE) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_reach_settle", 32'(found), 1);
        start_a = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready_a), 1);
        chk("mid_rst_done", 32'(done_a), 0);
        chk("mid_rst_cs", 32'(cs_a), 0);
        chk("mid_rst_circ_in", 32'(cin_a), 0);
        chk("mid_rst_be", 32'(be_a), 32'hF);
        for (int c = 0; c < OUT_CH; c++) chk($sformatf("mid_rst_sum%0d", c), sum_a[c*32 +: 32], 0);
        chk("mid_rst_state", 32'(dut_a.state), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_state", 32'(dut_a.state), 32'(ST_IDLE));
        chk("post_rst_ready", 32'(ready_a), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
